// File: rtl/dft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dft_pkg
// Brief    : Feeder state encoding and elaboration-time Hann/cos/sin generators.
// Revision : 1.0 - initial release
// ============================================================================
package dft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_STREAM    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_t;

    localparam real c_two_pi = 6.283185307179586;

    // Round-to-nearest into signed Q1.(w-1); the range is kept symmetric so a
    // negated coefficient can never overflow.
    function automatic int sat_round(input real x, input int w);
        real s;
        int  lim;
        int  v;
        lim = (1 << (w - 1)) - 1;
        s   = x * real'(1 << (w - 1));
        if (s >= 0.0) v = $rtoi(s + 0.5);
        else          v = -$rtoi(0.5 - s);
        if (v > lim)       v = lim;
        else if (v < -lim) v = -lim;
        return v;
    endfunction

    function automatic int hann_coeff(input int n, input int len, input int w);
        return sat_round(0.5 * (1.0 - $cos(c_two_pi * real'(n) / real'(len))), w);
    endfunction

    function automatic int cos_coeff(input int p, input int len, input int w);
        return sat_round($cos(c_two_pi * real'(p) / real'(len)), w);
    endfunction

    function automatic int sin_coeff(input int p, input int len, input int w);
        return sat_round($sin(c_two_pi * real'(p) / real'(len)), w);
    endfunction

endpackage : dft_pkg
`default_nettype wire

// File: rtl/dft_sample_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : dft_sample_feeder_if
// Brief    : Sample stream and accumulator-side signal bundle of the feeder.
//            DFT_FEEDER_STATS_EN adds the frames_o / drops_o counters.
// Revision : 1.0 - initial release
// ============================================================================
interface dft_sample_feeder_if #(
    parameter int IQ_WIDTH     = 16,
    parameter int WINDOW_WIDTH = 16,
    parameter int OSC_WIDTH    = 16,
    parameter int NUM_BINS     = 4
);
    logic                           frame_start_i;
    logic                           s_valid_i;
    logic                           s_ready_o;
    logic signed [IQ_WIDTH-1:0]     s_i_i;
    logic signed [IQ_WIDTH-1:0]     s_q_i;
    logic                           acc_busy_i;
    logic                           acc_valid_i;
    logic                           start_o;
    logic                           sample_valid_o;
    logic                           last_sample_o;
    logic signed [IQ_WIDTH-1:0]     i_sample_o;
    logic signed [IQ_WIDTH-1:0]     q_sample_o;
    logic signed [WINDOW_WIDTH-1:0] window_coeff_o;
    logic signed [OSC_WIDTH-1:0]    W_real_o [NUM_BINS];
    logic signed [OSC_WIDTH-1:0]    W_imag_o [NUM_BINS];
    logic                           frame_done_o;

`ifdef DFT_FEEDER_STATS_EN
    logic [31:0]                    frames_o;
    logic [15:0]                    drops_o;

    modport master (
        input  frame_start_i, s_valid_i, s_i_i, s_q_i, acc_busy_i, acc_valid_i,
        output s_ready_o, start_o, sample_valid_o, last_sample_o, i_sample_o,
               q_sample_o, window_coeff_o, W_real_o, W_imag_o, frame_done_o,
               frames_o, drops_o
    );

    modport slave (
        output frame_start_i, s_valid_i, s_i_i, s_q_i, acc_busy_i, acc_valid_i,
        input  s_ready_o, start_o, sample_valid_o, last_sample_o, i_sample_o,
               q_sample_o, window_coeff_o, W_real_o, W_imag_o, frame_done_o,
               frames_o, drops_o
    );
`else
    modport master (
        input  frame_start_i, s_valid_i, s_i_i, s_q_i, acc_busy_i, acc_valid_i,
        output s_ready_o, start_o, sample_valid_o, last_sample_o, i_sample_o,
               q_sample_o, window_coeff_o, W_real_o, W_imag_o, frame_done_o
    );

    modport slave (
        output frame_start_i, s_valid_i, s_i_i, s_q_i, acc_busy_i, acc_valid_i,
        input  s_ready_o, start_o, sample_valid_o, last_sample_o, i_sample_o,
               q_sample_o, window_coeff_o, W_real_o, W_imag_o, frame_done_o
    );
`endif

endinterface : dft_sample_feeder_if
`default_nettype wire

// File: rtl/dft_coeff_rom.sv
`default_nettype none
// ============================================================================
// Module   : dft_coeff_rom
// Brief    : N-entry Hann/cosine/sine table, one window read port plus one
//            combinational cos/sin read port per bin.
// Revision : 1.0 - initial release
// ============================================================================
module dft_coeff_rom
    import dft_pkg::*;
#(
    parameter int  FRAME_LEN    = 256,
    parameter int  WINDOW_WIDTH = 16,
    parameter int  OSC_WIDTH    = 16,
    parameter int  NUM_BINS     = 4,
    localparam int ADDR_W       = $clog2(FRAME_LEN)
) (
    input  wire        [ADDR_W-1:0]       win_addr,
    output logic signed [WINDOW_WIDTH-1:0] win_coeff,
    input  wire        [ADDR_W-1:0]       bin_addr [NUM_BINS],
    output logic signed [OSC_WIDTH-1:0]    bin_cos  [NUM_BINS],
    output logic signed [OSC_WIDTH-1:0]    bin_sin  [NUM_BINS]
);

    logic signed [WINDOW_WIDTH-1:0] w_hann_tab [FRAME_LEN];
    logic signed [OSC_WIDTH-1:0]    w_cos_tab  [FRAME_LEN];
    logic signed [OSC_WIDTH-1:0]    w_sin_tab  [FRAME_LEN];

    // Contents are fixed at elaboration; synthesis folds them into constants.
    for (genvar p = 0; p < FRAME_LEN; p++) begin : g_tab
        localparam int c_hann = hann_coeff(p, FRAME_LEN, WINDOW_WIDTH);
        localparam int c_cos  = cos_coeff(p, FRAME_LEN, OSC_WIDTH);
        localparam int c_sin  = sin_coeff(p, FRAME_LEN, OSC_WIDTH);
        assign w_hann_tab[p] = WINDOW_WIDTH'(c_hann);
        assign w_cos_tab[p]  = OSC_WIDTH'(c_cos);
        assign w_sin_tab[p]  = OSC_WIDTH'(c_sin);
    end

    assign win_coeff = w_hann_tab[win_addr];

    for (genvar b = 0; b < NUM_BINS; b++) begin : g_port
        assign bin_cos[b] = w_cos_tab[bin_addr[b]];
        assign bin_sin[b] = w_sin_tab[bin_addr[b]];
    end

endmodule : dft_coeff_rom
`default_nettype wire

// File: rtl/dft_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : dft_sample_feeder
// Brief    : Frames a ready/valid I/Q stream into FRAME_LEN windows and feeds
//            dft_accumulation with sample, Hann coefficient and per-bin
//            twiddles. DFT_FEEDER_STATS_EN adds frame/drop counters.
// Revision : 1.0 - initial release
// ============================================================================
module dft_sample_feeder
    import dft_pkg::*;
#(
    parameter int IQ_WIDTH     = 16,
    parameter int WINDOW_WIDTH = 16,
    parameter int OSC_WIDTH    = 16,
    parameter int NUM_BINS     = 4,
    parameter int FRAME_LEN    = 256,
    parameter int BIN_BASE     = 1,
    parameter int BIN_STEP     = 1
) (
    input  wire                 clk_i,
    input  wire                 rst_ni,
    dft_sample_feeder_if.master bus
);

    localparam int                  c_addr_w = $clog2(FRAME_LEN);
    localparam logic [c_addr_w-1:0] c_last_n = c_addr_w'(FRAME_LEN - 1);

    feeder_state_t r_state;
    feeder_state_t w_state_nxt;
    logic          w_start_ok;
    logic          w_handshake;

    logic [c_addr_w-1:0]           r_n;
    logic                          r_sample_valid;
    logic                          r_last;
    logic signed [IQ_WIDTH-1:0]    r_i;
    logic signed [IQ_WIDTH-1:0]    r_q;
    logic signed [WINDOW_WIDTH-1:0] r_win;

    logic        [c_addr_w-1:0]     w_bin_addr [NUM_BINS];
    logic signed [OSC_WIDTH-1:0]    w_bin_cos  [NUM_BINS];
    logic signed [OSC_WIDTH-1:0]    w_bin_sin  [NUM_BINS];
    logic signed [WINDOW_WIDTH-1:0] w_win;

    assign w_start_ok  = (r_state == ST_IDLE) && bus.frame_start_i && !bus.acc_busy_i;
    assign w_handshake = (r_state == ST_STREAM) && bus.s_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_start_ok) w_state_nxt = ST_START;
            ST_START:     w_state_nxt = ST_STREAM;
            ST_STREAM:    if (w_handshake && (r_n == c_last_n)) w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (bus.acc_valid_i) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes decode the state register only, so s_ready_o never
    // sees s_valid_i combinationally.
    assign bus.start_o      = (r_state == ST_START);
    assign bus.s_ready_o    = (r_state == ST_STREAM);
    assign bus.frame_done_o = (r_state == ST_WAIT_DONE) && bus.acc_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_n            <= '0;
            r_sample_valid <= 1'b0;
            r_last         <= 1'b0;
            r_i            <= '0;
            r_q            <= '0;
            r_win          <= '0;
        end else begin
            r_sample_valid <= w_handshake;
            r_last         <= w_handshake && (r_n == c_last_n);
            if (r_state == ST_START) begin
                r_n <= '0;
            end else if (w_handshake) begin
                r_n   <= r_n + 1'b1;
                r_i   <= bus.s_i_i;
                r_q   <= bus.s_q_i;
                r_win <= w_win;
            end
        end
    end

    assign bus.sample_valid_o = r_sample_valid;
    assign bus.last_sample_o  = r_last;
    assign bus.i_sample_o     = r_i;
    assign bus.q_sample_o     = r_q;
    assign bus.window_coeff_o = r_win;

    dft_coeff_rom #(
        .FRAME_LEN    (FRAME_LEN),
        .WINDOW_WIDTH (WINDOW_WIDTH),
        .OSC_WIDTH    (OSC_WIDTH),
        .NUM_BINS     (NUM_BINS)
    ) u_rom (
        .win_addr  (r_n),
        .win_coeff (w_win),
        .bin_addr  (w_bin_addr),
        .bin_cos   (w_bin_cos),
        .bin_sin   (w_bin_sin)
    );

    // Phase p_m = (k_m * n) mod N tracked incrementally; wrap is free at log2(N) bits.
    for (genvar m = 0; m < NUM_BINS; m++) begin : g_bin
        localparam int                  c_k   = BIN_BASE + m * BIN_STEP;
        localparam logic [c_addr_w-1:0] c_inc = c_addr_w'(c_k % FRAME_LEN);

        logic        [c_addr_w-1:0]  r_phase;
        logic signed [OSC_WIDTH-1:0] r_w_real;
        logic signed [OSC_WIDTH-1:0] r_w_imag;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_phase  <= '0;
                r_w_real <= '0;
                r_w_imag <= '0;
            end else if (r_state == ST_START) begin
                r_phase <= '0;
            end else if (w_handshake) begin
                r_w_real <= w_bin_cos[m];
                r_w_imag <= -w_bin_sin[m];
                r_phase  <= r_phase + c_inc;
            end
        end

        assign w_bin_addr[m]   = r_phase;
        assign bus.W_real_o[m] = r_w_real;
        assign bus.W_imag_o[m] = r_w_imag;
    end

`ifdef DFT_FEEDER_STATS_EN
    logic [31:0] r_frames;
    logic [15:0] r_drops;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_frames <= '0;
            r_drops  <= '0;
        end else begin
            if (bus.frame_done_o && (r_frames != '1)) r_frames <= r_frames + 1'b1;
            if (bus.frame_start_i && !w_start_ok && (r_drops != '1)) r_drops <= r_drops + 1'b1;
        end
    end

    assign bus.frames_o = r_frames;
    assign bus.drops_o  = r_drops;
`endif

endmodule : dft_sample_feeder
`default_nettype wire

// File: doc/dft_sample_feeder.md
# dft_sample_feeder

Front-end sequencer for `dft_accumulation`. It accepts a ready/valid I/Q sample stream and frames it into windows of FRAME_LEN samples. Per accepted sample it drives the accumulator's start, sample-valid and last-sample strobes, the I/Q sample, the window coefficient and one twiddle per bin. It then waits for the accumulator's result-valid before re-arming. The block sits between the ADC/decimator stream and the accumulator.

## Interface
- IQ_WIDTH, 16, I/Q sample width (signed).
- WINDOW_WIDTH, 16, window coefficient width, signed Q1.(WINDOW_WIDTH-1).
- OSC_WIDTH, 16, twiddle width, signed Q1.(OSC_WIDTH-1).
- NUM_BINS, 4, number of bins.
- FRAME_LEN, 256, samples per frame; power of two, at least 8.
- BIN_BASE, 1, index of the first bin.
- BIN_STEP, 1, bin spacing; bin m has index k_m = BIN_BASE + m*BIN_STEP.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- frame_start_i  in  1  request a frame (single-cycle pulse).
- s_valid_i  in  1  upstream sample valid.
- s_ready_o  out  1  upstream ready.
- s_i_i, s_q_i  in  IQ_WIDTH each  upstream I/Q sample.
- acc_busy_i  in  1  accumulator busy_o.
- acc_valid_i  in  1  accumulator valid_o.
- start_o  out  1  accumulator start.
- sample_valid_o  out  1  accumulator sample strobe.
- last_sample_o  out  1  accumulator last-sample strobe.
- i_sample_o, q_sample_o  out  IQ_WIDTH each  sample to the accumulator.
- window_coeff_o  out  WINDOW_WIDTH  h[n].
- W_real_o[NUM_BINS], W_imag_o[NUM_BINS]  out  OSC_WIDTH each  twiddle per bin.
- frame_done_o  out  1  one-cycle pulse when the accumulator result is valid.

## Operation
- FSM states: IDLE, START, STREAM, WAIT_DONE.
- IDLE → START on `frame_start_i && !acc_busy_i`.
- In START: `start_o`=1. The sample counter n and all phase accumulators are cleared. Next state is STREAM.
- In STREAM: `s_ready_o`=1. On each handshake (s_valid_i && s_ready_o), the sample with index n is registered:
  - `window_coeff_o` = Hann h[n] = 0.5(1−cos(2πn/N)), N = FRAME_LEN.
  - W_m = cos(2π·p_m/N) − j·sin(2π·p_m/N), where p_m = (k_m·n) mod N.
  - Each p_m is kept by its own log2(N)-bit phase accumulator, which adds k_m mod N per handshake. No multiplier is used.
- Coefficient scaling: +1.0 saturates to 2^(W−1)−1, where W is the relevant width. Values are rounded to nearest at elaboration.
- When the handshake with n = N−1 occurs, that sample also carries `last_sample_o`=1. The FSM then moves to WAIT_DONE and `s_ready_o` drops the next cycle.
- WAIT_DONE → IDLE on `acc_valid_i`. `frame_done_o` pulses in the same cycle.
- `frame_start_i` outside IDLE, or while `acc_busy_i`=1, is dropped; it is not queued.
- `s_valid_i` outside STREAM is not accepted. Upstream holds its data.
- Reset mid-frame: the FSM returns to IDLE immediately and all outputs go to zero. The frame in flight is discarded.

## Timing
- Reset values: every output is 0. W_real_o, W_imag_o, window_coeff_o and the samples reset to 0, not to the coefficient for n=0.
- `start_o` is high for exactly the one cycle spent in START. The earliest sample handshake is the first STREAM cycle.
- Handshake in cycle t → `sample_valid_o`, data and coefficients all valid and aligned in cycle t+1, for exactly one cycle.
- `sample_valid_o` never coincides with `start_o`.
- Throughput is one sample per cycle. Gaps in `s_valid_i` produce gaps in `sample_valid_o`.
- `s_ready_o` is a registered function of the state; it does not depend on `s_valid_i` (no combinational path).

## Configuration
- `DFT_FEEDER_STATS_EN` defined adds two outputs, each saturating at all-ones and cleared only by reset:
  - `frames_o` (32 bits): counts `frame_done_o` pulses.
  - `drops_o` (16 bits): counts dropped `frame_start_i` pulses.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `dft_pkg` holds:
  - the `feeder_state_t` enum;
  - elaboration-time functions `hann_coeff(n, N, W)`, `cos_coeff(p, N, W)` and `sin_coeff(p, N, W)`, which return saturated signed values.
- One sub-module, `dft_coeff_rom`: an N-entry cosine/sine table with NUM_BINS+1 combinational read ports. One port is used for the window, one per bin.

## Test plan
- N=8, NUM_BINS=2, BIN_BASE=1, BIN_STEP=1; stream 8 samples back-to-back → `start_o` once, then 8 `sample_valid_o` pulses in consecutive cycles. `last_sample_o` only on the 8th. Window sequence: 0, 4799, 16384, 27969, 32767, 27969, 16384, 4799.
- Same config, n=2 → bin 0 W=(0, −32767); bin 1 W=(−32767, 0).
- `s_valid_i` toggling every other cycle → `sample_valid_o` follows with 1-cycle latency. n advances only on handshakes. `last_sample_o` arrives on the 8th accepted sample.
- `frame_start_i` pulsed during STREAM and during WAIT_DONE → both ignored, FSM unaffected. With the macro defined, `drops_o`=2.
- `acc_valid_i` raised 5 cycles after the last sample → `frame_done_o` pulses in that cycle. A `frame_start_i` in the following cycle starts a new frame with n=0 and all phases at 0.
- `rst_ni` asserted at n=3 → all outputs 0 asynchronously. After release, the FSM is in IDLE and the next frame begins at n=0.
